// File: rtl/hilo_mdu_if.sv
// EX-stage request/response bundle between the pipeline and the HI/LO multiply/divide unit.
// The pipeline side is the master; hilo_mdu is the slave.
interface hilo_mdu_if;
  logic [31:0] Instr2;
  logic [31:0] A;
  logic [31:0] B2;
  logic        Start;
  logic        IntReq;
  logic        Rollback;
  logic [31:0] HILO;
  logic        Busy;

  modport master (
    output Instr2, A, B2, Start, IntReq, Rollback,
    input  HILO, Busy
  );

  modport slave (
    input  Instr2, A, B2, Start, IntReq, Rollback,
    output HILO, Busy
  );
endinterface

// File: rtl/hilo_mdu.sv
// Multi-cycle MULT/MULTU/DIV/DIVU responder owning the architectural HI/LO registers.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU are no-ops.
`default_nettype none

module hilo_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic clk,
  input  wire logic reset,
  hilo_mdu_if.slave bus
);

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;

  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  op_e         op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;
  logic        load, commit;

  // Instruction decode
  logic       special;
  logic [5:0] funct;
  logic       md_funct, accept, start_ok;
  logic       unused_instr;

  assign special      = (bus.Instr2[31:26] == 6'b000000);
  assign funct        = bus.Instr2[5:0];
  assign unused_instr = ^bus.Instr2[25:6];
  assign md_funct     = special && (funct[5:2] == 4'b0110);
`ifdef MDU_DIV_EN
  assign accept       = md_funct;
`else
  assign accept       = md_funct && !funct[1];
`endif
  assign start_ok     = bus.Start && accept && !bus.IntReq;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_RUN;
          load    = 1'b1;
          cnt_d   = funct[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end
      end
      S_RUN: begin
        if (bus.Rollback) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_IDLE;
            commit  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= OP_MULT;
      a_q  <= '0;
      b_q  <= '0;
    end else if (load) begin
      op_q <= op_e'(funct[1:0]);
      a_q  <= bus.A;
      b_q  <= bus.B2;
    end
  end

  // Sign-extending both operands for MULT lets one 64-bit multiplier serve both flavours.
  logic        sext;
  logic [63:0] prod;
  assign sext = (op_q == OP_MULT);
  assign prod = {{32{sext & a_q[31]}}, a_q} * {{32{sext & b_q[31]}}, b_q};

`ifdef MDU_DIV_EN
  // Divide magnitudes, then restore signs: quotient truncates toward zero and the
  // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  assign a_neg = (op_q == OP_DIV) & a_q[31];
  assign b_neg = (op_q == OP_DIV) & b_q[31];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;
`endif

  logic        res_ok;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    res_ok = 1'b1;
    res_hi = prod[63:32];
    res_lo = prod[31:0];
`ifdef MDU_DIV_EN
    if (op_q == OP_DIV || op_q == OP_DIVU) begin
      res_ok = (b_q != 32'd0);
      res_hi = rem;
      res_lo = quot;
    end
`endif
  end

  // MT writes land only while idle; a result commit can only happen from RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      if (res_ok) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end else if (state_q == S_IDLE && !bus.IntReq && special) begin
      if (funct == F_MTHI) hi_q <= bus.A;
      if (funct == F_MTLO) lo_q <= bus.A;
    end
  end

  assign bus.Busy = (state_q == S_RUN);
  assign bus.HILO = (special && funct == F_MFHI) ? hi_q :
                    (special && funct == F_MFLO) ? lo_q : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_hilo_mdu.sv
// Scoreboard bench for hilo_mdu: stimulus queues expected HILO/Busy per cycle from an
// arithmetic reference model; a negedge monitor pops and compares.
module tb_hilo_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [5:0] F_NOP   = 6'h00;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic clk = 1'b0;
  logic reset = 1'b0;

  hilo_mdu_if bus ();

  hilo_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hilo;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;

  // Reference model state: architectural HI/LO plus remaining busy cycles and pending result.
  logic [31:0] m_hi, m_lo, pend_hi, pend_lo;
  bit          pend_ok;
  int          busy_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard_underflow: output seen with no expectation at %0t", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, ".hilo"}, bus.HILO, e.hilo);
          check({e.name, ".busy"}, {31'd0, bus.Busy}, {31'd0, e.busy});
        end
      end
    end
  end

  function automatic bit is_md(input logic [5:0] f);
`ifdef MDU_DIV_EN
    return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
`else
    return f inside {F_MULT, F_MULTU};
`endif
  endfunction

  // Result computed with 64-bit integer arithmetic straight from the ISA definition.
  task automatic model_issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    logic [63:0] p;
    pend_ok = 1'b1;
    pend_hi = m_hi;
    pend_lo = m_lo;
    if (f == F_MULT || f == F_DIV) begin
      x = longint'(int'(a));
      y = longint'(int'(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    if (f == F_MULT || f == F_MULTU) begin
      p = 64'(x * y);
      pend_hi = p[63:32];
      pend_lo = p[31:0];
    end else if (b == 32'd0) begin
      pend_ok = 1'b0;
    end else begin
      q = x / y;
      r = x % y;
      pend_hi = r[31:0];
      pend_lo = q[31:0];
    end
  endtask

  task automatic step(input string name, input logic [5:0] op, input logic [5:0] f,
                      input logic [31:0] a, input logic [31:0] b,
                      input bit start, input bit irq, input bit rb);
    exp_t e;
    bus.Instr2   = {op, 20'($urandom), f};
    bus.A        = a;
    bus.B2       = b;
    bus.Start    = start;
    bus.IntReq   = irq;
    bus.Rollback = rb;
    e.name = name;
    e.busy = (busy_left > 0);
    e.hilo = (op == 6'd0 && f == F_MFHI) ? m_hi :
             (op == 6'd0 && f == F_MFLO) ? m_lo : 32'd0;
    sb.push_back(e);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    if (busy_left > 0) begin
      if (rb) busy_left = 0;
      else begin
        busy_left--;
        if (busy_left == 0 && pend_ok) begin
          m_hi = pend_hi;
          m_lo = pend_lo;
        end
      end
    end else if (op == 6'd0 && !irq) begin
      if (start && is_md(f)) begin
        model_issue(f, a, b);
        busy_left = (f == F_MULT || f == F_MULTU) ? MULT_N : DIV_N;
      end else if (f == F_MTHI) m_hi = a;
      else if (f == F_MTLO) m_lo = a;
    end
  endtask

  task automatic wait_op(input string name, input int n);
    for (int i = 0; i < n; i++)
      step(name, 6'd0, (i % 2 == 0) ? F_MFHI : F_MFLO, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset falls mid-cycle; the next negedge must already show Busy=0 and HI=LO=0.
  task automatic reset_probe(input string name);
    exp_t e;
    #2 reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    busy_left = 0;
    bus.Start = 1'b0;
    bus.IntReq = 1'b0;
    bus.Rollback = 1'b0;
    bus.Instr2 = {26'd0, F_MFHI};
    e.name = {name, "_hi"}; e.hilo = 32'd0; e.busy = 1'b0;
    sb.push_back(e);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    bus.Instr2 = {26'd0, F_MFLO};
    e.name = {name, "_lo"};
    sb.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.Instr2 = '0; bus.A = '0; bus.B2 = '0;
    bus.Start = 1'b0; bus.IntReq = 1'b0; bus.Rollback = 1'b0;
    m_hi = '0; m_lo = '0; pend_hi = '0; pend_lo = '0; pend_ok = 1'b0; busy_left = 0;
    @(posedge clk);
    #1;
    reset_probe("por");

    step("mthi",  6'd0, F_MTHI, 32'h0000_AAAA, 32'd0, 1'b0, 1'b0, 1'b0);
    step("mtlo",  6'd0, F_MTLO, 32'h0000_5555, 32'd0, 1'b0, 1'b0, 1'b0);
    step("mfhi0", 6'd0, F_MFHI, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step("mflo0", 6'd0, F_MFLO, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    step("mult_neg", 6'd0, F_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 1'b0);
    wait_op("mult_neg_w", MULT_N + 2);
    step("multu", 6'd0, F_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 1'b0);
    wait_op("multu_w", MULT_N + 2);

    step("div_neg", 6'd0, F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0);
    wait_op("div_neg_w", DIV_N + 2);
    step("div_ovf", 6'd0, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    wait_op("div_ovf_w", DIV_N + 2);
    step("divu_z", 6'd0, F_DIVU, 32'h0000_1234, 32'd0, 1'b1, 1'b0, 1'b0);
    wait_op("divu_z_w", DIV_N + 2);

    step("start_irq", 6'd0, F_MULT, 32'd7, 32'd9, 1'b1, 1'b1, 1'b0);
    wait_op("start_irq_w", 2);
    step("mthi_irq", 6'd0, F_MTHI, 32'h0000_1234, 32'd0, 1'b0, 1'b1, 1'b0);
    wait_op("mthi_irq_w", 2);

    step("mthi_rb", 6'd0, F_MTHI, 32'h0000_AAAA, 32'd0, 1'b0, 1'b0, 1'b0);
    step("mtlo_rb", 6'd0, F_MTLO, 32'h0000_5555, 32'd0, 1'b0, 1'b0, 1'b0);
    step("mult_rb", 6'd0, F_MULT, 32'd7, 32'd9, 1'b1, 1'b0, 1'b0);
    wait_op("mult_rb_w", 2);
    step("rollback", 6'd0, F_MFHI, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    wait_op("after_rb", 3);

    step("nonspecial", 6'h23, F_MULT, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
    wait_op("nonspecial_w", 2);

`ifdef MDU_DIV_EN
    step("div_rst", 6'd0, F_DIV, 32'h1234_5678, 32'd7, 1'b1, 1'b0, 1'b0);
`else
    step("divu_off", 6'd0, F_DIVU, 32'h1234_5678, 32'd7, 1'b1, 1'b0, 1'b0);
    wait_op("divu_off_w", 3);
    step("mult_rst", 6'd0, F_MULT, 32'h1234_5678, 32'd7, 1'b1, 1'b0, 1'b0);
`endif
    wait_op("pre_rst", 2);
    reset_probe("mid_rst");

    for (int n = 0; n < 400; n++) begin
      int          k;
      logic [5:0]  op, f;
      logic [31:0] a, b;
      bit          st, irq, rb;
      k   = $urandom_range(0, 11);
      a   = pick();
      b   = pick();
      irq = ($urandom_range(0, 9) == 0);
      rb  = ($urandom_range(0, 24) == 0);
      op  = 6'd0;
      st  = 1'b0;
      case (k)
        0, 1, 2, 3: begin f = F_MULT + 6'($urandom_range(0, 3)); st = (busy_left == 0); end
        4:          begin f = F_MTHI; st = (busy_left == 0) && ($urandom_range(0, 1) == 1); end
        5:          f = F_MTLO;
        6, 7:       f = F_MFHI;
        8, 9:       f = F_MFLO;
        10:         f = F_NOP;
        default:    begin op = 6'h23; f = F_MULT; st = (busy_left == 0); end
      endcase
      step("rnd", op, f, a, b, st, irq, rb);
    end
    wait_op("drain", DIV_N + 2);

    chk_en = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Multi-cycle multiply/divide responder with the architectural HI/LO registers, serving the EX stage of the five-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU on a one-cycle `Start` pulse and reports `Busy` while the operation runs. It executes MTHI/MTLO, returns HI or LO on `HILO` for MFHI/MFLO, and cancels or aborts work on `IntReq` and `Rollback`.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU (valid range 1..15).
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU (valid range 1..15).

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low. Low clears all state immediately.
- `Instr2` input 32: EX-stage instruction. Op `[31:26]` and funct `[5:0]` are decoded here.
- `A` input 32: forwarded rs operand.
- `B2` input 32: forwarded rt operand.
- `Start` input 1: one-cycle request from decode for a MULT/MULTU/DIV/DIVU now in EX.
- `IntReq` input 1: interrupt/exception taken this cycle; the EX instruction is being flushed.
- `Rollback` input 1: abort the in-flight operation.
- `HILO` output 32: HI for MFHI, LO for MFLO, 0 otherwise. Combinational.
- `Busy` output 1: registered; high while an operation is in flight.

## Operation
- Decode applies only when Op=000000. Funct codes:
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
- Two states:
  - IDLE: `Busy`=0.
  - RUN: `Busy`=1; a 4-bit down-counter and a 2-bit op latch are held.
- IDLE→RUN requires `Start`=1, a mult/div funct, and `IntReq`=0 on the same edge.
  - On that edge: latch `A`, `B2`, and the op; load the counter with `MULT_CYCLES` or `DIV_CYCLES`.
  - `Start` with a non-mult/div instruction is ignored.
- In RUN, the counter decrements each edge. On the edge where it goes from 1 to 0:
  - HI/LO commit the result.
  - State returns to IDLE.
- Results:
  - MULT/MULTU: {HI,LO} = 64-bit signed/unsigned product of the latched operands.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the dividend's sign.
- Boundary conditions:
  - Divisor 0: full latency is spent, HI/LO are left unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- HI/LO commit only at completion, so before that they hold their pre-operation values.
- MTHI/MTLO write `A` into HI/LO on the edge when `Busy`=0 and `IntReq`=0.
  - If `Busy`=1 they are ignored; the hazard unit stalls them.
- `Rollback`=1 in RUN: state goes to IDLE on that edge and HI/LO are unchanged.
  - `Rollback` and completion on the same edge: `Rollback` wins and nothing is committed.
  - `Rollback` in IDLE: no effect.
- `Start` while `Busy`=1 is ignored; the hazard unit guarantees this does not occur.

## Timing
- Reset values: `Busy`=0, HI=0, LO=0, counter=0, state IDLE, `HILO`=0 when no MF instruction is present.
- `Start` sampled at edge T: `Busy`=1 from T until the edge T+N, where N is the op latency. `Busy`=0 and the new HI/LO are visible after edge T+N.
  - For MULT_CYCLES=5: `Busy` is high for exactly 5 cycles.
- The hazard unit stalls on `Start | Busy` for MF/MT/mult/div, so `Busy` carries no combinational path from `Start`.
- MFHI/MFLO issued after `Busy` falls reads the new value in the same cycle.
- Reset asserted mid-operation: `Busy` drops immediately and asynchronously; HI=LO=0.

## Configuration
- `MDU_DIV_EN` defined: the DIV/DIVU datapath is built as described above.
- `MDU_DIV_EN` undefined: DIV/DIVU are treated as no-ops.
  - `Start` with a div funct stays in IDLE and `Busy` stays 0.
  - HI/LO are unchanged.
  - No divider logic is synthesized.

## Test plan
- MULT with A=0xFFFFFFFE (−2), B2=3, `Start` at T → `Busy` high T..T+5; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with A=0xFFFFFFFF, B2=2 → HI=0x00000001, LO=0xFFFFFFFE. Then MFHI → `HILO`=1 and MFLO → `HILO`=0xFFFFFFFE.
- DIV with A=−7 (0xFFFFFFF9), B2=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles. DIVU with B2=0 → HI/LO unchanged.
- `Start` together with `IntReq`=1 → `Busy` stays 0 and HI/LO are unchanged. MTHI with A=0x1234 and `IntReq`=1 → HI is unchanged.
- MULT in flight with `Rollback` pulsed at the third busy cycle → `Busy`=0 on the next cycle and HI/LO keep their old values (e.g. 0xAAAA/0x5555).
- `reset` driven low during DIV → `Busy`=0 immediately; HI=LO=0. With `MDU_DIV_EN` undefined, `Start` on DIVU → `Busy` never rises.
